// File: rtl/dmem_ram_arbiter.sv
// Two-master arbiter (CPU load/store, read-only DMA scanout) for the single-port data RAM window.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin on contention instead of CPU fixed priority.
module dmem_ram_arbiter #(
    parameter logic [31:0] RAM_BASE  = 32'd8500,
    parameter logic [31:0] RAM_LIMIT = 32'd138100,
    parameter int          MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rd,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rd,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd,
    output logic        err_oob
);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_e;

    state_e      state_q;
    logic [3:0]  dma_wait_q, dma_wait_d;
    logic        rd_pend_q;
    logic        oob_q;
    logic        cpu_win, dma_win, granted, oob;
    logic [31:0] win_addr;
    logic        dma_forced;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_cpu_q;
`endif

    assign dma_forced = (dma_wait_q == 4'(MAX_WAIT));

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (!reset) begin
            if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                dma_win = dma_forced || last_cpu_q;
`else
                dma_win = dma_forced;
`endif
                cpu_win = !dma_win;
            end else begin
                cpu_win = cpu_req;
                dma_win = dma_req;
            end
        end
    end

    assign granted  = cpu_win || dma_win;
    assign win_addr = dma_win ? dma_addr : cpu_addr;
    assign oob      = granted && ((win_addr < RAM_BASE) || (win_addr >= RAM_LIMIT));

    assign cpu_gnt  = cpu_win;
    assign dma_gnt  = dma_win;
    assign err_oob  = oob;
    assign ram_we   = cpu_win && cpu_we && !oob;
    assign ram_addr = (granted && !oob) ? (win_addr - RAM_BASE) : 32'd0;
    assign ram_wd   = cpu_win ? cpu_wd : 32'd0;

    always_comb begin
        dma_wait_d = 4'd0;
        if (dma_req && !dma_win)
            dma_wait_d = dma_forced ? dma_wait_q : dma_wait_q + 4'd1;
    end

    // state_q doubles as the return owner tag: it names whoever was granted last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dma_wait_q <= 4'd0;
            rd_pend_q  <= 1'b0;
            oob_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_cpu_q <= 1'b1;
`endif
        end else begin
            state_q    <= cpu_win ? CPU_ACC : (dma_win ? DMA_ACC : IDLE);
            dma_wait_q <= dma_wait_d;
            rd_pend_q  <= dma_win || (cpu_win && !cpu_we);
            oob_q      <= oob;
`ifdef ARB_ROUND_ROBIN_EN
            if (granted)
                last_cpu_q <= cpu_win;
`endif
        end
    end

    // A return in flight when reset rises is suppressed immediately, not one cycle later.
    assign cpu_rvalid = !reset && rd_pend_q && (state_q == CPU_ACC);
    assign dma_rvalid = !reset && rd_pend_q && (state_q == DMA_ACC);
    assign cpu_rd     = (cpu_rvalid && !oob_q) ? ram_rd : 32'd0;
    assign dma_rd     = (dma_rvalid && !oob_q) ? ram_rd : 32'd0;

endmodule
